// File: rtl/pdm_speaker_out.sv
// PDM speaker driver: 4-deep sample FIFO feeding a first-order sigma-delta
// modulator, with amplifier shutdown after a run of starved frames.
module pdm_speaker_out #(
  parameter int CLK_DIV     = 32,
  parameter int OSR         = 64,
  parameter int IDLE_FRAMES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] data_spk,
  input  logic        data_spk_valid,
  output logic        data_spk_ready,
  output logic        pdm_out_o,
  output logic        pdm_sd_o,
  output logic        underrun_o
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FRAME_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int UND_W   = $clog2(IDLE_FRAMES + 1);

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(OSR - 1);
  localparam logic [UND_W-1:0]   UND_LAST   = UND_W'(IDLE_FRAMES - 1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t state_q, state_d;

  logic [DIV_W-1:0]   div_q;
  logic [FRAME_W-1:0] frame_q;
  logic               bit_tick;
  logic               frame_end;

  logic [15:0] mem [0:3];
  logic [1:0]  wr_ptr_q;
  logic [1:0]  rd_ptr_q;
  logic [2:0]  count_q;
  logic        push;
  logic        pop;
  logic        starve;
  logic        go_idle;

  logic [15:0]      cur_sample_q;
  logic [15:0]      acc_q;
  logic [16:0]      mod_sum;
  logic [UND_W-1:0] und_q;

  assign bit_tick       = (div_q == DIV_LAST);
  assign frame_end      = bit_tick && (frame_q == FRAME_LAST);
  assign data_spk_ready = (count_q != 3'd4);
  assign push           = data_spk_valid && data_spk_ready;
  assign pdm_sd_o       = (state_q == ST_RUN);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q   <= '0;
      frame_q <= '0;
    end else begin
      div_q <= bit_tick ? '0 : div_q + DIV_W'(1);
      if (bit_tick) begin
        frame_q <= (frame_q == FRAME_LAST) ? '0 : frame_q + FRAME_W'(1);
      end
    end
  end

  // Frame-boundary decisions: start-up needs two queued samples so the
  // first pop is not immediately followed by a starved frame.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    starve  = 1'b0;
    go_idle = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_end && (count_q >= 3'd2)) begin
          pop     = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (frame_end) begin
          if (count_q != 3'd0) begin
            pop = 1'b1;
          end else begin
            starve = 1'b1;
            if (und_q == UND_LAST) begin
              go_idle = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Storage needs no reset: clearing pointers and count discards it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= data_spk;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_sample_q <= '0;
      underrun_o   <= 1'b0;
      und_q        <= '0;
    end else begin
      underrun_o <= starve;
      if (pop) begin
        cur_sample_q <= mem[rd_ptr_q];
        und_q        <= '0;
      end else if (starve) begin
        cur_sample_q <= 16'h0000;
        und_q        <= go_idle ? '0 : und_q + UND_W'(1);
      end
    end
  end

  // Offset-binary input makes the carry density track the signed sample.
  assign mod_sum = {1'b0, acc_q} + {1'b0, cur_sample_q ^ 16'h8000};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q     <= '0;
      pdm_out_o <= 1'b0;
    end else if ((state_q != ST_RUN) || go_idle) begin
      acc_q     <= '0;
      pdm_out_o <= 1'b0;
    end else if (bit_tick) begin
      acc_q     <= mod_sum[15:0];
      pdm_out_o <= mod_sum[16];
    end
  end

endmodule
